// File: rtl/jvm_fetch_pkg.sv
// Shared definitions for the JVM bytecode fetcher and the translator that drives it.
//   fetch_state_e : fetcher FSM encodings
//   OPC_WIDE      : the 'wide' opcode prefix
//   byte_lane()   : pick one byte of a big-endian word (lane 0 = bits [31:24])
package jvm_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_PREFETCH = 2'd2
  } fetch_state_e;

  localparam logic [7:0] OPC_WIDE = 8'hC4;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bytecode_ram.sv
// Bytecode image memory: SIZE x 32 bits, one synchronous write port (image load)
// and one synchronous read port. A read and a write to the same word on the same
// edge return the old contents.
//   clk            : clock
//   wr_en/wr_addr/wr_data : image-load write port
//   rd_addr        : read word address, sampled on posedge
//   rd_data        : read data, valid the cycle after rd_addr was presented
module bytecode_ram #(
  parameter int SIZE          = 256,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [SIZE];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/jvm_bytecode_fetcher.sv
// Bytecode-fetch responder for the JVM->ARM translator. Holds the bytecode image,
// a byte program counter and a one-word line buffer; returns one byte per start.
// Optional feature macro: JVM_FETCH_PREFETCH_EN (silent one-cycle line prefetch).
//   clk        : clock
//   reset      : asynchronous active-low reset
//   start      : fetch request pulse (ignored while busy)
//   pc_reset   : synchronous PC clear + buffer invalidate (priority over start)
//   ready      : one-cycle pulse, next_byte valid
//   next_byte  : fetched byte, held until the next ready
//   busy       : a line fill is in flight
//   wrapped    : sticky, PC rolled over from SIZE*4-1 to 0
//   load_en/load_addr/load_data : image-load write port
//
// state    | meaning
// IDLE     | waiting for start; hits served directly from the line buffer
// FILL     | memory read of the PC word in flight; closes with ready
// PREFETCH | silent line fill while idle (JVM_FETCH_PREFETCH_EN only)
module jvm_bytecode_fetcher
  import jvm_fetch_pkg::*;
#(
  parameter int SIZE          = 256,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pc_reset,
  output logic                     ready,
  output logic [7:0]               next_byte,
  output logic                     busy,
  output logic                     wrapped,
  input  logic                     load_en,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int PC_W = ADDRESS_WIDTH + 2;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_e             state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [31:0]              buf_data_q, buf_data_d;
  logic [ADDRESS_WIDTH-1:0] tag_q, tag_d;
  logic                     valid_q, valid_d;
  logic                     ready_q, ready_d;
  logic [7:0]               next_byte_q, next_byte_d;
  logic                     wrapped_q, wrapped_d;
  // A load to the word being filled, on the edge that launched the read, makes
  // the fill data stale even though it is returned to the translator.
  logic                     stale_q, stale_d;
`ifdef JVM_FETCH_PREFETCH_EN
  logic                     pending_q, pending_d;
`endif

  logic [ADDRESS_WIDTH-1:0] pc_word;
  logic [1:0]               pc_lane;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [31:0]              rd_data;
  logic                     req;
  logic                     hit;
  logic                     load_hits_pc;

  assign pc_word      = pc_q[PC_W-1:2];
  assign pc_lane      = pc_q[1:0];
  assign hit          = valid_q && (tag_q == pc_word);
  assign load_hits_pc = load_en && (load_addr == pc_word);
  // The read launched alongside pc_reset must already target word 0.
  assign rd_addr      = pc_reset ? '0 : pc_word;

  bytecode_ram #(
    .SIZE          (SIZE),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_data_d  = buf_data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    ready_d     = 1'b0;
    next_byte_d = next_byte_q;
    wrapped_d   = wrapped_q;
    stale_d     = 1'b0;
`ifdef JVM_FETCH_PREFETCH_EN
    pending_d   = pending_q;
    req         = (start && (state_q != ST_FILL)) || pending_q;
`else
    req         = start && (state_q != ST_FILL);
`endif

    if (load_en && (load_addr == tag_q)) valid_d = 1'b0;

    if (pc_reset) begin
      pc_d      = '0;
      valid_d   = 1'b0;
      wrapped_d = 1'b0;
`ifdef JVM_FETCH_PREFETCH_EN
      pending_d = 1'b0;
`endif
      if (start && (state_q != ST_FILL)) begin
        state_d = ST_FILL;
        stale_d = load_en && (load_addr == '0);
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
`ifdef JVM_FETCH_PREFETCH_EN
            pending_d = 1'b0;
`endif
            if (hit) begin
              next_byte_d = byte_lane(buf_data_q, pc_lane);
              ready_d     = 1'b1;
              pc_d        = pc_q + PC_ONE;
              if (pc_q == '1) wrapped_d = 1'b1;
            end else begin
              state_d = ST_FILL;
              stale_d = load_hits_pc;
            end
          end
`ifdef JVM_FETCH_PREFETCH_EN
          else if (!load_en && !hit) begin
            state_d = ST_PREFETCH;
          end
`endif
        end
        ST_FILL: begin
          buf_data_d  = rd_data;
          tag_d       = pc_word;
          valid_d     = !(stale_q || load_hits_pc);
          next_byte_d = byte_lane(rd_data, pc_lane);
          ready_d     = 1'b1;
          pc_d        = pc_q + PC_ONE;
          if (pc_q == '1) wrapped_d = 1'b1;
          state_d     = ST_IDLE;
        end
`ifdef JVM_FETCH_PREFETCH_EN
        ST_PREFETCH: begin
          buf_data_d = rd_data;
          tag_d      = pc_word;
          valid_d    = !(stale_q || load_hits_pc);
          if (start) pending_d = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      buf_data_q  <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      next_byte_q <= 8'h00;
      wrapped_q   <= 1'b0;
      stale_q     <= 1'b0;
`ifdef JVM_FETCH_PREFETCH_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_data_q  <= buf_data_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      next_byte_q <= next_byte_d;
      wrapped_q   <= wrapped_d;
      stale_q     <= stale_d;
`ifdef JVM_FETCH_PREFETCH_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign next_byte = next_byte_q;
  assign busy      = (state_q == ST_FILL);
  assign wrapped   = wrapped_q;

endmodule
